// File: rtl/multicycle_controlunit_pkg.sv
// ----------------------------------------------------------------------------
// cu_pkg: shared types and encodings for the multicycle control unit. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CL_RTYPE   = 3'd0,
    CL_LI      = 3'd1,
    CL_ADDI    = 3'd2,
    CL_LW      = 3'd3,
    CL_SW      = 3'd4,
    CL_BEQ     = 3'd5,
    CL_ILLEGAL = 3'd6
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LI    = 6'b111111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;

  function automatic logic uses_imm(input iclass_e c);
    return (c == CL_ADDI) || (c == CL_LW) || (c == CL_SW);
  endfunction

  // Writeback from the immediate/memory path rather than the ALU result.
  function automatic logic writes_from_imm(input iclass_e c);
    return (c == CL_LI) || (c == CL_LW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controlunit_decode.sv
// ----------------------------------------------------------------------------
// cu_decode: maps (opcode, functcode) to instruction class and ALU select. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cu_decode
  import cu_pkg::*;
#(
  parameter int unsigned OPW     = 6,
  parameter int unsigned FNW     = 6,
  parameter int unsigned ALUSELW = 3
) (
  input  logic [OPW-1:0]     opcode_i,
  input  logic [FNW-1:0]     functcode_i,
  output iclass_e            class_o,
  output logic [ALUSELW-1:0] alusel_o
);

  always_comb begin
    class_o  = CL_ILLEGAL;
    alusel_o = '0;
    case (opcode_i)
      OPW'(OP_RTYPE): begin
        class_o = CL_RTYPE;
        case (functcode_i)
          FNW'(FN_ADD): alusel_o = ALUSELW'(ALU_ADD);
          FNW'(FN_SUB): alusel_o = ALUSELW'(ALU_SUB);
          FNW'(FN_AND): alusel_o = ALUSELW'(ALU_AND);
          FNW'(FN_OR):  alusel_o = ALUSELW'(ALU_OR);
          FNW'(FN_SLL): alusel_o = ALUSELW'(ALU_SLL);
          FNW'(FN_SRL): alusel_o = ALUSELW'(ALU_SRL);
          default:      class_o  = CL_ILLEGAL;
        endcase
      end
      OPW'(OP_LI): begin
        class_o  = CL_LI;
        alusel_o = ALUSELW'(ALU_ADD);
      end
      OPW'(OP_ADDI): begin
        class_o  = CL_ADDI;
        alusel_o = ALUSELW'(ALU_ADD);
      end
      OPW'(OP_LW): begin
        class_o  = CL_LW;
        alusel_o = ALUSELW'(ALU_ADD);
      end
      OPW'(OP_SW): begin
        class_o  = CL_SW;
        alusel_o = ALUSELW'(ALU_ADD);
      end
      OPW'(OP_BEQ): begin
        class_o  = CL_BEQ;
        alusel_o = ALUSELW'(ALU_SUB);
      end
      default: begin
        class_o  = CL_ILLEGAL;
        alusel_o = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controlunit.sv
// ----------------------------------------------------------------------------
// multicycle_controlunit: FETCH/DECODE/EXEC/MEM/WB sequencer with retire count. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multicycle_controlunit
  import cu_pkg::*;
#(
  parameter int unsigned OPW     = 6,
  parameter int unsigned FNW     = 6,
  parameter int unsigned ALUSELW = 3,
  parameter int unsigned CNTW    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPW-1:0]     opcode,
  input  logic [FNW-1:0]     functcode,
  input  logic               mem_ready,
  input  logic               zero,
  output logic [ALUSELW-1:0] alusel,
  output logic               writesel,
  output logic               writereg,
  output logic               alusrc_imm,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               instr_done,
  output logic               illegal,
  output logic [CNTW-1:0]    retired
);

  state_e             state_q;
  state_e             state_d;
  iclass_e            class_q;
  logic [ALUSELW-1:0] alusel_q;
  logic [CNTW-1:0]    retired_q;

  iclass_e            dec_class;
  logic [ALUSELW-1:0] dec_alusel;

  logic [ALUSELW-1:0] w_alusel;
  logic               w_writesel;
  logic               w_writereg;
  logic               w_alusrc_imm;
  logic               w_memread;
  logic               w_memwrite;
  logic               w_irwrite;
  logic               w_pcwrite;
  logic               w_instr_done;
  logic               w_illegal;

  cu_decode #(
    .OPW     (OPW),
    .FNW     (FNW),
    .ALUSELW (ALUSELW)
  ) u_decode (
    .opcode_i    (opcode),
    .functcode_i (functcode),
    .class_o     (dec_class),
    .alusel_o    (dec_alusel)
  );

  always_comb begin
    state_d      = state_q;
    w_alusel     = '0;
    w_writesel   = 1'b0;
    w_writereg   = 1'b0;
    w_alusrc_imm = 1'b0;
    w_memread    = 1'b0;
    w_memwrite   = 1'b0;
    w_irwrite    = 1'b0;
    w_pcwrite    = 1'b0;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        w_memread = 1'b1;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
        state_d   = mem_ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        w_illegal = (dec_class == CL_ILLEGAL);
        state_d   = w_illegal ? ST_FETCH : ST_EXEC;
      end
      ST_EXEC: begin
        w_alusel     = alusel_q;
        w_alusrc_imm = uses_imm(class_q);
        if (class_q == CL_BEQ) begin
          w_pcwrite    = zero;
          w_instr_done = 1'b1;
          state_d      = ST_FETCH;
        end else if ((class_q == CL_LW) || (class_q == CL_SW)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        w_alusel     = alusel_q;
        w_alusrc_imm = uses_imm(class_q);
        w_memread    = (class_q == CL_LW);
        w_memwrite   = (class_q == CL_SW);
        if (mem_ready) begin
          w_instr_done = (class_q == CL_SW);
          state_d      = (class_q == CL_SW) ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        w_alusel     = alusel_q;
        w_alusrc_imm = uses_imm(class_q);
        w_writesel   = writes_from_imm(class_q);
        w_writereg   = 1'b1;
        w_instr_done = 1'b1;
        state_d      = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      class_q   <= CL_RTYPE;
      alusel_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        class_q  <= dec_class;
        alusel_q <= dec_alusel;
      end
      if (w_instr_done) begin
        retired_q <= retired_q + CNTW'(1);
      end
    end
  end

  // Reset forces every output low combinationally, even before the first edge.
  assign alusel     = reset ? '0   : w_alusel;
  assign writesel   = reset ? 1'b0 : w_writesel;
  assign writereg   = reset ? 1'b0 : w_writereg;
  assign alusrc_imm = reset ? 1'b0 : w_alusrc_imm;
  assign memread    = reset ? 1'b0 : w_memread;
  assign memwrite   = reset ? 1'b0 : w_memwrite;
  assign irwrite    = reset ? 1'b0 : w_irwrite;
  assign pcwrite    = reset ? 1'b0 : w_pcwrite;
  assign instr_done = reset ? 1'b0 : w_instr_done;
  assign illegal    = reset ? 1'b0 : w_illegal;
  assign retired    = reset ? '0   : retired_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controlunit.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controlunit: directed per-cycle checks of the control unit. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_controlunit;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] functcode;
  logic       mem_ready;
  logic       zero;

  logic [2:0]  alusel;
  logic        writesel, writereg, alusrc_imm, memread, memwrite;
  logic        irwrite, pcwrite, instr_done, illegal;
  logic [15:0] retired;

  logic [2:0]  alusel2;
  logic        writesel2, writereg2, alusrc_imm2, memread2, memwrite2;
  logic        irwrite2, pcwrite2, instr_done2, illegal2;
  logic [1:0]  retired2;

  int n_checks;
  int n_fail;
  int exp_ret;

  multicycle_controlunit #(.OPW(6), .FNW(6), .ALUSELW(3), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .functcode(functcode),
    .mem_ready(mem_ready), .zero(zero), .alusel(alusel), .writesel(writesel),
    .writereg(writereg), .alusrc_imm(alusrc_imm), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite),
    .instr_done(instr_done), .illegal(illegal), .retired(retired)
  );

  multicycle_controlunit #(.OPW(6), .FNW(6), .ALUSELW(3), .CNTW(2)) dut_wrap (
    .clk(clk), .reset(reset), .opcode(opcode), .functcode(functcode),
    .mem_ready(mem_ready), .zero(zero), .alusel(alusel2), .writesel(writesel2),
    .writereg(writereg2), .alusrc_imm(alusrc_imm2), .memread(memread2),
    .memwrite(memwrite2), .irwrite(irwrite2), .pcwrite(pcwrite2),
    .instr_done(instr_done2), .illegal(illegal2), .retired(retired2)
  );

  logic [11:0] outv;
  assign outv = {alusel, writesel, writereg, alusrc_imm, memread, memwrite,
                 irwrite, pcwrite, instr_done, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs expected outputs in the same order as outv.
  function automatic logic [11:0] ov(input logic [2:0] a, input logic ws, input logic wr,
                                     input logic imm, input logic mr, input logic mw,
                                     input logic ir, input logic pc, input logic dn,
                                     input logic il);
    return {a, ws, wr, imm, mr, mw, ir, pc, dn, il};
  endfunction

  localparam logic [11:0] V_ZERO  = 12'b000_0_0_0_0_0_0_0_0_0;
  localparam logic [11:0] V_FETCH = 12'b000_0_0_0_1_0_1_1_0_0;
  localparam logic [11:0] V_FWAIT = 12'b000_0_0_0_1_0_0_0_0_0;
  localparam logic [11:0] V_ILL   = 12'b000_0_0_0_0_0_0_0_0_1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the outputs, advance past the edge.
  task automatic cyc(input string tag, input logic rdy, input logic z,
                     input logic [5:0] op, input logic [5:0] fn, input logic [11:0] exp);
    mem_ready = rdy;
    zero      = z;
    opcode    = op;
    functcode = fn;
    #2;
    check(tag, {20'b0, outv}, {20'b0, exp});
    if (exp[1]) exp_ret++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input string tag);
    check({tag, "_ret"}, {16'b0, retired}, exp_ret);
    check({tag, "_ret2"}, {30'b0, retired2}, exp_ret % 4);
  endtask

  task automatic fetch(input string tag);
    chk_ret(tag);
    cyc({tag, "_f"}, 1'b1, 1'b0, 6'h00, 6'h00, V_FETCH);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_ret   = 0;
    reset     = 1'b1;
    mem_ready = 1'b1;
    zero      = 1'b0;
    opcode    = 6'h00;
    functcode = 6'h00;
    #1;
    for (int i = 0; i < 2; i++) begin
      cyc("rst_out", 1'b1, 1'b0, 6'h00, 6'h00, V_ZERO);
    end
    reset = 1'b0;

    // R-type add; opcode changes during EXEC must be ignored
    fetch("add");
    cyc("add_dec", 1'b1, 1'b0, 6'h00, 6'b100000, V_ZERO);
    cyc("add_ex",  1'b1, 1'b0, 6'h3F, 6'h3F, ov(3'd0,0,0,0,0,0,0,0,0,0));
    cyc("add_wb",  1'b1, 1'b0, 6'h3F, 6'h3F, ov(3'd0,0,1,0,0,0,0,0,1,0));

    fetch("sub");
    cyc("sub_dec", 1'b1, 1'b0, 6'h00, 6'b100010, V_ZERO);
    cyc("sub_ex",  1'b1, 1'b0, 6'h00, 6'h00, ov(3'd1,0,0,0,0,0,0,0,0,0));
    cyc("sub_wb",  1'b1, 1'b0, 6'h00, 6'h00, ov(3'd1,0,1,0,0,0,0,0,1,0));

    fetch("sll");
    cyc("sll_dec", 1'b1, 1'b0, 6'h00, 6'b000000, V_ZERO);
    cyc("sll_ex",  1'b1, 1'b0, 6'h00, 6'h00, ov(3'd4,0,0,0,0,0,0,0,0,0));
    cyc("sll_wb",  1'b1, 1'b0, 6'h00, 6'h00, ov(3'd4,0,1,0,0,0,0,0,1,0));

    fetch("li");
    cyc("li_dec", 1'b1, 1'b0, 6'b111111, 6'h00, V_ZERO);
    cyc("li_ex",  1'b1, 1'b0, 6'h00, 6'h00, ov(3'd0,0,0,0,0,0,0,0,0,0));
    cyc("li_wb",  1'b1, 1'b0, 6'h00, 6'h00, ov(3'd0,1,1,0,0,0,0,0,1,0));

    fetch("addi");
    cyc("addi_dec", 1'b1, 1'b0, 6'b001000, 6'h00, V_ZERO);
    cyc("addi_ex",  1'b1, 1'b0, 6'h00, 6'h00, ov(3'd0,0,0,1,0,0,0,0,0,0));
    cyc("addi_wb",  1'b1, 1'b0, 6'h00, 6'h00, ov(3'd0,0,1,1,0,0,0,0,1,0));

    // LW with three wait cycles in MEM: 8 cycles total
    fetch("lw");
    cyc("lw_dec", 1'b1, 1'b0, 6'b100011, 6'h00, V_ZERO);
    cyc("lw_ex",  1'b1, 1'b0, 6'h00, 6'h00, ov(3'd0,0,0,1,0,0,0,0,0,0));
    for (int i = 0; i < 3; i++) begin
      cyc("lw_memwait", 1'b0, 1'b0, 6'h00, 6'h00, ov(3'd0,0,0,1,1,0,0,0,0,0));
    end
    cyc("lw_memack", 1'b1, 1'b0, 6'h00, 6'h00, ov(3'd0,0,0,1,1,0,0,0,0,0));
    cyc("lw_wb",     1'b1, 1'b0, 6'h00, 6'h00, ov(3'd0,1,1,1,0,0,0,0,1,0));

    fetch("beq1");
    cyc("beq1_dec", 1'b1, 1'b1, 6'b000100, 6'h00, V_ZERO);
    cyc("beq1_ex",  1'b1, 1'b1, 6'h00, 6'h00, ov(3'd1,0,0,0,0,0,0,1,1,0));
    fetch("beq0");
    cyc("beq0_dec", 1'b1, 1'b0, 6'b000100, 6'h00, V_ZERO);
    cyc("beq0_ex",  1'b1, 1'b0, 6'h00, 6'h00, ov(3'd1,0,0,0,0,0,0,0,1,0));

    fetch("illop");
    cyc("illop_dec", 1'b1, 1'b0, 6'b010101, 6'h00, V_ILL);
    fetch("illfn");
    cyc("illfn_dec", 1'b1, 1'b0, 6'h00, 6'b111111, V_ILL);

    // SW with one FETCH wait cycle
    chk_ret("sw");
    cyc("sw_fwait", 1'b0, 1'b0, 6'h00, 6'h00, V_FWAIT);
    cyc("sw_f",     1'b1, 1'b0, 6'h00, 6'h00, V_FETCH);
    cyc("sw_dec",   1'b1, 1'b0, 6'b101011, 6'h00, V_ZERO);
    cyc("sw_ex",    1'b1, 1'b0, 6'h00, 6'h00, ov(3'd0,0,0,1,0,0,0,0,0,0));
    cyc("sw_mem",   1'b1, 1'b0, 6'h00, 6'h00, ov(3'd0,0,0,1,0,1,0,0,1,0));

    // Reset during SW MEM wait aborts the store
    fetch("swr");
    cyc("swr_dec", 1'b1, 1'b0, 6'b101011, 6'h00, V_ZERO);
    cyc("swr_ex",  1'b1, 1'b0, 6'h00, 6'h00, ov(3'd0,0,0,1,0,0,0,0,0,0));
    cyc("swr_mem", 1'b0, 1'b0, 6'h00, 6'h00, ov(3'd0,0,0,1,0,1,0,0,0,0));
    reset = 1'b1;
    cyc("swr_rst", 1'b1, 1'b0, 6'h00, 6'h00, V_ZERO);
    reset   = 1'b0;
    exp_ret = 0;
    chk_ret("swr_after");
    cyc("swr_resume", 1'b0, 1'b0, 6'h00, 6'h00, V_FWAIT);

    // Five BEQ retirements: 2-bit counter wraps to 1
    for (int i = 0; i < 5; i++) begin
      fetch("wrap");
      cyc("wrap_dec", 1'b1, 1'b0, 6'b000100, 6'h00, V_ZERO);
      cyc("wrap_ex",  1'b1, 1'b0, 6'h00, 6'h00, ov(3'd1,0,0,0,0,0,0,0,1,0));
    end
    chk_ret("wrap_end");
    check("wrap_cnt2", {30'b0, retired2}, 32'd1);
    check("wrap_cnt16", {16'b0, retired}, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_controlunit.md
# multicycle_controlunit

Multicycle successor to the single-cycle control unit: a clocked FSM that walks each instruction through fetch, decode, execute, memory and writeback. It drives the datapath's ALU select, register-write, memory and PC-update strobes. It handshakes with instruction/data memory via `mem_ready`, and counts retired instructions. Widths of opcode, function code, ALU select and retire counter are parametrised.

## Interface
- `OPW`, 6, opcode width
- `FNW`, 6, function-code width
- `ALUSELW`, 3, ALU select width (must be ≥ 3)
- `CNTW`, 16, retired-instruction counter width
- `clk`  input  1  single clock, rising edge
- `reset`  input  1  synchronous, active-high
- `opcode`  input  OPW  instruction-register opcode field
- `functcode`  input  FNW  instruction-register function field
- `mem_ready`  input  1  memory ack for the current fetch/load/store
- `zero`  input  1  ALU zero flag
- `alusel`  output  ALUSELW  ALU operation
- `writesel`  output  1  writeback source: 0 = ALU, 1 = immediate/memory
- `writereg`  output  1  register-file write strobe
- `alusrc_imm`  output  1  ALU B operand from immediate
- `memread`, `memwrite`  output  1  memory strobes
- `irwrite`  output  1  load instruction register
- `pcwrite`  output  1  update PC
- `instr_done`  output  1  one-cycle pulse on retirement
- `illegal`  output  1  one-cycle pulse on an undecodable instruction
- `retired`  output  CNTW  count of retired instructions

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB.
- FETCH:
  - `memread`=1.
  - When `mem_ready`=1: `irwrite`=1, `pcwrite`=1, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: latch `opcode`/`functcode` internally and classify the instruction.
  - R-type (opcode 0): funct 100000 add→000, 100010 sub→001, 100100 and→010, 100101 or→011, 000000 sll→100, 000010 srl→101.
  - Any other funct: illegal.
  - 111111 LI: writesel=1.
  - 001000 ADDI: alu add, imm.
  - 100011 LW: add, imm, writesel=1.
  - 101011 SW: add, imm.
  - 000100 BEQ: sub.
  - Any other opcode: illegal.
- Illegal instruction: pulse `illegal` in DECODE, return to FETCH, no writes, no `instr_done`.
- EXEC:
  - `alusel`/`alusrc_imm` driven per class; they are held through MEM/WB.
  - BEQ: `pcwrite`=`zero`, `instr_done`=1, then go to FETCH.
  - LW/SW: go to MEM.
  - All others: go to WB.
- MEM:
  - LW drives `memread`; SW drives `memwrite`.
  - Strobe held until `mem_ready`=1.
  - SW retires on `mem_ready` and goes to FETCH; LW goes to WB.
- WB: `writereg`=1, `writesel` per class, `instr_done`=1, then go to FETCH.
- `retired` increments on each `instr_done` and wraps modulo 2^CNTW.
- Strobes not listed as active in a state are 0; `alusel` is 0 outside EXEC/MEM/WB. Outputs are never X.

## Timing
- `reset` high at a clock edge:
  - state becomes FETCH, latched fields become 0, `retired` becomes 0.
  - While `reset` is high, all outputs are 0, including `memread`.
- Reset asserted mid-instruction aborts it: no `writereg`, `memwrite` or `instr_done` follows.
- `irwrite`, `pcwrite` (FETCH), `instr_done` and `writereg` are Mealy on `mem_ready`/`zero` where noted; all other outputs are Moore on the state.
- Latency with `mem_ready` tied to 1: R/LI/ADDI 4 cycles, BEQ 3, SW 4, LW 5.
- Each cycle that `mem_ready` is low adds one cycle in FETCH or MEM.
- `opcode`/`functcode` are only sampled in DECODE; changes in later states have no effect.
- `retired` updates on the edge that ends the `instr_done` cycle.

## Structure
- Package `cu_pkg`: state enum; opcode and funct localparams; ALU-select codes; instruction-class enum (RTYPE, LI, ADDI, LW, SW, BEQ, ILLEGAL).
- Sub-module `cu_decode`: combinational mapping of (opcode, functcode) to (class, alusel). It is instantiated once, feeding the DECODE-state latch.

## Test plan
- `reset` 1 for 2 cycles, then released → all outputs 0 during reset; first cycle after release has `memread`=1; `retired`=0.
- R-type add (opcode 0, funct 100000), `mem_ready`=1 → `alusel`=000 in EXEC and WB; `writereg`=1 and `instr_done`=1 in cycle 4; `retired`=1.
- LW with `mem_ready` low for 3 cycles in MEM → `memread` held for 4 cycles; `writereg` with `writesel`=1 one cycle after ack; total 8 cycles.
- BEQ with `zero`=1, then BEQ with `zero`=0 → `pcwrite`=1 in EXEC only for the first; both retire in 3 cycles.
- Opcode 010101, or R-type funct 111111 → `illegal` pulses in DECODE, no `writereg`/`memwrite`, `retired` unchanged, next cycle is FETCH.
- Reset asserted during SW MEM wait → no `memwrite` after reset; FETCH resumes. Separately, with CNTW=2, five retirements → `retired`=1 (wrap).
